// File: rtl/setting_mode_editor_pkg.sv
// Shared definitions for the setting-mode editor: mode codes, session states,
// item codes and the item-stepping helper.
package setting_mode_editor_pkg;

   // Top-level mode encoding reused from the mode FSM
   localparam int MODE_WIDTH = 3;
   localparam logic [MODE_WIDTH-1:0] POWER_OFF_MODE = 3'd0;
   localparam logic [MODE_WIDTH-1:0] STAND_MODE     = 3'd1;

   // Setting session states
   localparam int SET_STATE_WIDTH = 2;
   typedef enum logic [SET_STATE_WIDTH-1:0] {
      SET_IDLE   = 2'd0,
      SET_ACTIVE = 2'd1,
      SET_EXIT   = 2'd2
   } set_state_t;

   // Editable items, in select order
   localparam int ITEM_WIDTH = 2;
   localparam logic [ITEM_WIDTH-1:0] ITEM_WORK    = 2'd0;
   localparam logic [ITEM_WIDTH-1:0] ITEM_GESTURE = 2'd1;
   localparam logic [ITEM_WIDTH-1:0] ITEM_REMIND  = 2'd2;

   // Select button cycles work -> gesture -> remind -> work
   function automatic logic [ITEM_WIDTH-1:0] next_item(input logic [ITEM_WIDTH-1:0] item);
      return (item == ITEM_REMIND) ? ITEM_WORK : item + 2'd1;
   endfunction

endpackage

// File: rtl/setting_mode_editor_bounded_wrap_counter.sv
// Parameter register that steps by one within [MIN, MAX] and wraps at both ends.
// inc and dec together leave the value unchanged.
module bounded_wrap_counter #(
   parameter int WIDTH = 5,
   parameter int MIN   = 1,
   parameter int MAX   = 24,
   parameter int DEF   = 10
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             en,
   input  logic             inc,
   input  logic             dec,
   output logic [WIDTH-1:0] value
);

   localparam logic [WIDTH-1:0] MIN_V = WIDTH'(MIN);
   localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
   localparam logic [WIDTH-1:0] DEF_V = WIDTH'(DEF);
   localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);

   // Step up or down when enabled, wrapping past the bounds
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         value <= DEF_V;
      end else if (en && inc && !dec) begin
         value <= (value == MAX_V) ? MIN_V : value + ONE_V;
      end else if (en && dec && !inc) begin
         value <= (value == MIN_V) ? MAX_V : value - ONE_V;
      end
   end

endmodule

// File: rtl/setting_mode_editor.sv
// Setting session editor: entered from STAND by enter_toggle, edits three hood
// parameters with select/inc/dec, leaves on a toggle edge or inactivity timeout
// with a one-cycle exit_toggle pulse. POWER_OFF aborts silently.
module setting_mode_editor
   import setting_mode_editor_pkg::*;
#(
   parameter int TIMEOUT_S      = 30,
   parameter int WORK_LIMIT_DEF = 10,
   parameter int WORK_LIMIT_MAX = 24,
   parameter int GESTURE_DEF    = 5,
   parameter int GESTURE_MAX    = 9,
   parameter int REMIND_DEF     = 10,
   parameter int REMIND_MAX     = 99
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic [MODE_WIDTH-1:0] current_mode,
   input  logic                  enter_toggle,
   input  logic                  toggle_signal,
   input  logic                  select_signal,
   input  logic                  inc_signal,
   input  logic                  dec_signal,
   input  logic                  tick_1s,
   output logic                  setting_active,
   output logic                  exit_toggle,
   output logic [1:0]            sel_item,
   output logic [4:0]            work_limit,
   output logic [3:0]            gesture_time,
   output logic [6:0]            remind_hours
);

   localparam logic [5:0] TIMEOUT_LAST = 6'(TIMEOUT_S - 1);

   set_state_t state;
   logic [5:0] idle_cnt;
   logic       toggle_d, select_d, inc_d, dec_d;
   logic       toggle_edge, select_edge, inc_edge, dec_edge;
   logic       abort, in_active, edit_en, activity, timeout_hit;

   assign toggle_edge = toggle_signal & ~toggle_d;
   assign select_edge = select_signal & ~select_d;
   assign inc_edge    = inc_signal & ~inc_d;
   assign dec_edge    = dec_signal & ~dec_d;

   assign abort       = (current_mode == POWER_OFF_MODE);
   assign in_active   = (state == SET_ACTIVE) && !abort;
   // Toggle ends the session and select takes precedence over value edits
   assign edit_en     = in_active && !toggle_edge && !select_edge;
   assign activity    = select_edge | inc_edge | dec_edge;
   assign timeout_hit = tick_1s && !activity && (idle_cnt == TIMEOUT_LAST);

   // Button delay registers run in every state so held buttons never re-trigger
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         toggle_d <= 1'b0;
         select_d <= 1'b0;
         inc_d    <= 1'b0;
         dec_d    <= 1'b0;
      end else begin
         toggle_d <= toggle_signal;
         select_d <= select_signal;
         inc_d    <= inc_signal;
         dec_d    <= dec_signal;
      end
   end

   // Session FSM with registered status outputs, item select and idle timer
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state          <= SET_IDLE;
         setting_active <= 1'b0;
         exit_toggle    <= 1'b0;
         sel_item       <= ITEM_WORK;
         idle_cnt       <= 6'd0;
      end else if (abort) begin
         state          <= SET_IDLE;
         setting_active <= 1'b0;
         exit_toggle    <= 1'b0;
         sel_item       <= ITEM_WORK;
         idle_cnt       <= 6'd0;
      end else begin
         exit_toggle <= 1'b0;
         case (state)
            SET_IDLE: begin
               if (current_mode == STAND_MODE && enter_toggle) begin
                  state          <= SET_ACTIVE;
                  setting_active <= 1'b1;
                  sel_item       <= ITEM_WORK;
                  idle_cnt       <= 6'd0;
               end
            end
            SET_ACTIVE: begin
               if (toggle_edge || timeout_hit) begin
                  state          <= SET_EXIT;
                  setting_active <= 1'b0;
                  exit_toggle    <= 1'b1;
               end else begin
                  if (select_edge) begin
                     sel_item <= next_item(sel_item);
                  end
                  if (activity) begin
                     idle_cnt <= 6'd0;
                  end else if (tick_1s) begin
                     idle_cnt <= idle_cnt + 6'd1;
                  end
               end
            end
            SET_EXIT: begin
               state <= SET_IDLE;
            end
            default: begin
               state          <= SET_IDLE;
               setting_active <= 1'b0;
            end
         endcase
      end
   end

   bounded_wrap_counter #(
      .WIDTH(5), .MIN(1), .MAX(WORK_LIMIT_MAX), .DEF(WORK_LIMIT_DEF)
   ) u_work (
      .clk(clk), .rstn(rstn),
      .en(edit_en && sel_item == ITEM_WORK),
      .inc(inc_edge), .dec(dec_edge),
      .value(work_limit)
   );

   bounded_wrap_counter #(
      .WIDTH(4), .MIN(1), .MAX(GESTURE_MAX), .DEF(GESTURE_DEF)
   ) u_gesture (
      .clk(clk), .rstn(rstn),
      .en(edit_en && sel_item == ITEM_GESTURE),
      .inc(inc_edge), .dec(dec_edge),
      .value(gesture_time)
   );

   bounded_wrap_counter #(
      .WIDTH(7), .MIN(1), .MAX(REMIND_MAX), .DEF(REMIND_DEF)
   ) u_remind (
      .clk(clk), .rstn(rstn),
      .en(edit_en && sel_item == ITEM_REMIND),
      .inc(inc_edge), .dec(dec_edge),
      .value(remind_hours)
   );

endmodule

// File: doc/setting_mode_editor.md
Name: setting_mode_editor

Overview:
- Receiving end of the stand-mode toggle pulse `setting_mode_controller_normal_toggle`.
- On that pulse, enters an active setting session in which the user edits three hood parameters with select/inc/dec buttons.
- Session ends on a toggle-button rising edge or on an inactivity timeout; at session end the block emits a one-cycle `exit_toggle` pulse so the top-level mode FSM can return to STAND.
- Parameter registers hold their values between sessions and feed the runtime controllers.

Parameters:
- TIMEOUT_S, 30, seconds without an accepted button edge before the session auto-exits (range 1..63).
- WORK_LIMIT_DEF, 10, reset value of the work-time limit in hours.
- WORK_LIMIT_MAX, 24, maximum work-time limit (minimum is 1).
- GESTURE_DEF, 5, reset value of the gesture switch time in seconds.
- GESTURE_MAX, 9, maximum gesture time (minimum is 1).
- REMIND_DEF, 10, reset value of the clean-reminder interval in hours.
- REMIND_MAX, 99, maximum reminder interval (minimum is 1).

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- current_mode  in  `MODE_WIDTH  top-level mode.
- enter_toggle  in  1  one-cycle pulse from the normal setting controller.
- toggle_signal  in  1  raw toggle button level, used for exit.
- select_signal  in  1  raw select button level.
- inc_signal  in  1  raw increment button level.
- dec_signal  in  1  raw decrement button level.
- tick_1s  in  1  one-cycle pulse once per second.
- setting_active  out  1  high while the session is ACTIVE.
- exit_toggle  out  1  one-cycle pulse requesting return to STAND.
- sel_item  out  2  currently edited item.
- work_limit  out  5  work-time limit in hours.
- gesture_time  out  4  gesture switch time in seconds.
- remind_hours  out  7  clean-reminder interval in hours.

Behaviour:
- Reset and clocking:
  - One clock domain, clk.
  - Reset is asynchronous and active-low on rstn.
  - All outputs are registered.
  - Reset values: setting_active=0, exit_toggle=0, sel_item=0, work_limit=WORK_LIMIT_DEF, gesture_time=GESTURE_DEF, remind_hours=REMIND_DEF, state=IDLE, idle_cnt=0, all edge-delay registers=0.
- Edge detection: a rising edge is registered as !x_d && x. The delay registers sample the raw buttons every cycle in every state, so a button still held when a session starts does not re-trigger.
- FSM: IDLE -> ACTIVE -> EXIT -> IDLE.
- IDLE:
  - Transitions to ACTIVE when current_mode==`STAND_MODE && enter_toggle.
  - On entry: sel_item<=0, idle_cnt<=0.
  - setting_active rises one cycle after enter_toggle.
- ACTIVE, priority order within one cycle:
  - 1) toggle rising edge -> EXIT.
  - 2) select edge -> sel_item steps 0->1->2->0.
  - 3) inc/dec edge on the selected item:
    - inc at max wraps to 1; dec at 1 wraps to max.
    - inc and dec together: value unchanged, but counted as activity.
  - Any accepted edge clears idle_cnt.
  - tick_1s with no accepted edge in the same cycle increments idle_cnt.
  - tick_1s arriving while idle_cnt==TIMEOUT_S-1 -> EXIT.
  - An edge arriving on the same cycle as tick_1s wins: counter clears and there is no timeout.
- EXIT: lasts exactly one cycle.
  - exit_toggle=1 and setting_active=0 during that cycle.
  - Next state is IDLE.
  - enter_toggle during EXIT is ignored.
- Abort: current_mode==`POWER_OFF_MODE in any state forces IDLE next cycle with no exit_toggle. Parameter values are retained and sel_item<=0.
- Edits take effect on the cycle after the edge. A value update is always exactly ±1 or a wrap.
- Session length is unbounded while buttons keep arriving.

Decomposition:
- Shared header parameters.vh gains:
  - `SET_IDLE, `SET_ACTIVE, `SET_EXIT (2-bit state codes).
  - `ITEM_WORK=0, `ITEM_GESTURE=1, `ITEM_REMIND=2.
  - `SET_STATE_WIDTH, `ITEM_WIDTH.
  - The existing `STAND_MODE / `POWER_OFF_MODE / `MODE_WIDTH are reused.
- One natural sub-module: `bounded_wrap_counter` (parameters WIDTH, MIN, MAX, DEF; inputs inc, dec, en), instantiated three times.
- Edge detectors are inline.

Test Plan:
- Reset, then current_mode=STAND with a one-cycle enter_toggle -> setting_active=1 next cycle, sel_item=0, work_limit=10.
- In ACTIVE: three inc edges -> work_limit 13. Select then a dec edge -> sel_item=1, gesture_time 4. Set gesture_time to 9, then inc -> gesture_time wraps to 1.
- Toggle rising edge in ACTIVE -> exit_toggle high for exactly one cycle, setting_active=0, state IDLE, and edited values retained.
- No buttons with 30 tick_1s pulses -> exit_toggle fires on the cycle after the 30th tick. Repeat with an inc edge coincident with tick 30 -> no exit, idle_cnt=0.
- Toggle and select edges in the same cycle -> EXIT and sel_item unchanged. Inc and dec in the same cycle -> value unchanged and timeout restarted.
- POWER_OFF mid-session -> IDLE next cycle, no exit_toggle, values kept. Assert rstn mid-session -> all outputs return to defaults immediately.
